// File: rtl/lenet_feeder.sv
// Streams one IMG_DIM x IMG_DIM frame out of the LeNet input buffer as a valid/ready pixel stream.
// Buffer reads are metered so that a stalled consumer never causes a returned word to be dropped.
module lenet_feeder #(
    parameter int ACC_D_SIZE = 9,
    parameter int IMG_DIM    = 32,
    parameter int ADDR_W     = 10,
    parameter int SHIFT      = 6,
    parameter int OUT_W      = 8
) (
    input  logic                  clk25,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_en,
    input  logic [ACC_D_SIZE:0]   rd_data,
    output logic [OUT_W-1:0]      px_data,
    output logic                  px_valid,
    input  logic                  px_ready,
    output logic                  px_first,
    output logic                  px_last,
    output logic                  busy,
    output logic                  done
);

    localparam int IN_W = ACC_D_SIZE + 1;
    localparam int WW   = IN_W + OUT_W;
    localparam int NPIX = IMG_DIM * IMG_DIM;
    localparam int EW   = OUT_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_en_q, rd_en_d;
    logic                issued_any_q, issued_any_d;
    logic                en_first_q, en_first_d;
    logic                en_last_q, en_last_d;
    logic                vld_q, vld_d;
    logic                vld_first_q, vld_first_d;
    logic                vld_last_q, vld_last_d;
    logic [EW-1:0]       fifo_mem_q [2];
    logic [EW-1:0]       fifo_mem_d [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          occ_q, occ_d;
    logic [OUT_W-1:0]    px_data_q, px_data_d;
    logic                px_valid_q, px_valid_d;
    logic                px_first_q, px_first_d;
    logic                px_last_q, px_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [IN_W-1:0]     shifted;
    logic [WW-1:0]       shifted_w;
    logic [OUT_W-1:0]    norm;
    logic [EW-1:0]       ret_entry;
    logic [2:0]          in_sys;
    logic [2:0]          limit;
    logic                leaving;
    logic                issue;
    logic                more_reads;
    logic [ADDR_W-1:0]   issue_addr;
    logic                load;
    logic                push;
    logic                pop;

    // Saturating normalisation of the returned buffer word.
    assign shifted   = rd_data >> SHIFT;
    assign shifted_w = WW'(shifted);
    assign norm      = (shifted_w > WW'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : shifted_w[OUT_W-1:0];
    assign ret_entry = {vld_first_q, vld_last_q, norm};

    // Words held or en route: output stage + FIFO + word on the bus + read just issued.
    // A read is issued only if every such word still has a slot even if the consumer stalls
    // from now on; when px_ready is low the outgoing beat cannot be counted on, so the limit drops.
    assign in_sys     = {2'b0, px_valid_q} + {1'b0, occ_q} + {2'b0, vld_q} + {2'b0, rd_en_q};
    assign leaving    = px_valid_q & px_ready;
    assign limit      = px_ready ? 3'd3 : 3'd2;
    assign more_reads = !issued_any_q || (rd_addr_q != LAST_ADDR);
    assign issue_addr = issued_any_q ? rd_addr_q + ADDR_W'(1) : '0;
    assign load       = !px_valid_q || px_ready;

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        issued_any_d = issued_any_q;
        en_first_d   = en_first_q;
        en_last_d    = en_last_q;
        issue        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    issue   = 1'b1;
                end
            end
            S_STREAM: begin
                issue = more_reads && ((in_sys - {2'b0, leaving}) < limit);
                if (px_valid_q && px_ready && px_last_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                rd_addr_d    = '0;
                issued_any_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        rd_en_d = issue;
        if (issue) begin
            rd_addr_d    = issue_addr;
            issued_any_d = 1'b1;
            en_first_d   = (issue_addr == '0);
            en_last_d    = (issue_addr == LAST_ADDR);
        end

        vld_d       = rd_en_q;
        vld_first_d = en_first_q;
        vld_last_d  = en_last_q;

        busy_d = (state_d == S_STREAM);
        done_d = (state_d == S_DONE);
    end

    // Output stage refills from the FIFO head first; the bus word bypasses an empty FIFO.
    always_comb begin
        px_data_d   = px_data_q;
        px_valid_d  = px_valid_q;
        px_first_d  = px_first_q;
        px_last_d   = px_last_q;
        fifo_mem_d  = fifo_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pop         = 1'b0;

        if (load) begin
            if (occ_q != 2'd0) begin
                {px_first_d, px_last_d, px_data_d} = fifo_mem_q[rd_ptr_q];
                px_valid_d = 1'b1;
                pop        = 1'b1;
            end else if (vld_q) begin
                {px_first_d, px_last_d, px_data_d} = ret_entry;
                px_valid_d = 1'b1;
            end else begin
                px_valid_d = 1'b0;
            end
        end

        push = vld_q && !(load && (occ_q == 2'd0));
        if (push) begin
            fifo_mem_d[wr_ptr_q] = ret_entry;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rd_addr_q     <= '0;
            rd_en_q       <= 1'b0;
            issued_any_q  <= 1'b0;
            en_first_q    <= 1'b0;
            en_last_q     <= 1'b0;
            vld_q         <= 1'b0;
            vld_first_q   <= 1'b0;
            vld_last_q    <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
            px_data_q     <= '0;
            px_valid_q    <= 1'b0;
            px_first_q    <= 1'b0;
            px_last_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            rd_en_q       <= rd_en_d;
            issued_any_q  <= issued_any_d;
            en_first_q    <= en_first_d;
            en_last_q     <= en_last_d;
            vld_q         <= vld_d;
            vld_first_q   <= vld_first_d;
            vld_last_q    <= vld_last_d;
            fifo_mem_q    <= fifo_mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            px_data_q     <= px_data_d;
            px_valid_q    <= px_valid_d;
            px_first_q    <= px_first_d;
            px_last_q     <= px_last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign rd_addr  = rd_addr_q;
    assign rd_en    = rd_en_q;
    assign px_data  = px_data_q;
    assign px_valid = px_valid_q;
    assign px_first = px_first_q;
    assign px_last  = px_last_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_lenet_feeder.sv
// Bench for lenet_feeder: behavioural buffer + expected-pixel model, randomized data and
// back-pressure, stall/restart/reset scenarios, all checked through one comparison task.
module tb_lenet_feeder;

    localparam int NPIX  = 1024;
    localparam int SHIFT = 6;
    localparam int PXMAX = 255;

    logic       clk25 = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       px_ready = 1'b1;
    logic [9:0] rd_addr;
    logic       rd_en;
    logic [9:0] rd_data;
    logic [7:0] px_data;
    logic       px_valid, px_first, px_last, busy, done;

    int mem [NPIX];

    int n_chk = 0;
    int n_fail = 0;
    int fcyc, beats, issued, exp_rd, done_cnt, first_valid, last_beat, done_cyc;
    int rdy_mode;
    bit hold;
    logic [7:0] hold_data;
    logic hold_first, hold_last;

    lenet_feeder dut (
        .clk25    (clk25),
        .rst      (rst),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .px_data  (px_data),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .px_first (px_first),
        .px_last  (px_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk25 = ~clk25;

    // Buffer model: synchronous read, data one cycle after rd_en.
    always @(posedge clk25) begin
        if (rd_en) rd_data <= 10'(mem[rd_addr]);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_px(input int k);
        int v;
        v = mem[k] >> SHIFT;
        return (v > PXMAX) ? PXMAX : v;
    endfunction

    task automatic sample();
        int n_out;
        fcyc++;
        if (rst) begin
            hold = 1'b0;
        end else begin
            n_out = issued + int'(rd_en) - beats - int'(px_valid);
            chk("outstanding_le2", int'(n_out <= 2), 1);
            if (rd_en) begin
                chk("rd_addr", int'(rd_addr), exp_rd);
                chk("rd_budget", int'(issued < NPIX), 1);
                issued++;
                exp_rd++;
            end
            if (hold) begin
                chk("stall_valid", int'(px_valid), 1);
                chk("stall_data", int'(px_data), int'(hold_data));
                chk("stall_first", int'(px_first), int'(hold_first));
                chk("stall_last", int'(px_last), int'(hold_last));
            end
            if (px_valid && first_valid < 0) first_valid = fcyc;
            if (px_valid && px_ready) begin
                if (beats < NPIX) begin
                    chk("px_data", int'(px_data), exp_px(beats));
                    chk("px_first", int'(px_first), int'(beats == 0));
                    chk("px_last", int'(px_last), int'(beats == NPIX - 1));
                end else begin
                    chk("beat_overrun", beats, NPIX - 1);
                end
                beats++;
                last_beat = fcyc;
            end
            hold       = px_valid && !px_ready;
            hold_data  = px_data;
            hold_first = px_first;
            hold_last  = px_last;
            if (done) begin
                done_cnt++;
                done_cyc = fcyc;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk25);
        sample();
        @(posedge clk25);
        #1;
        case (rdy_mode)
            1:       px_ready = 1'($urandom_range(0, 1));
            2:       px_ready = 1'b0;
            default: px_ready = 1'b1;
        endcase
    endtask

    task automatic begin_frame();
        beats = 0; issued = 0; exp_rd = 0; done_cnt = 0;
        first_valid = -1; last_beat = -1; done_cyc = -1; hold = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        fcyc = -1;
        chk("busy_rise", int'(busy), 1);
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done_cnt == 0 && n < limit) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("done_once", done_cnt, 1);
        chk("beats", beats, NPIX);
        chk("done_after_last", done_cyc, last_beat + 1);
        chk("busy_low_after", int'(busy), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        int v;
        v = int'(rd_addr) + int'(rd_en) + int'(px_data) + int'(px_valid) + int'(px_first)
            + int'(px_last) + int'(busy) + int'(done);
        chk(tag, v, 0);
    endtask

    initial begin
        int n, snap_issued, snap_beats;
        fcyc = 0; beats = 0; issued = 0; exp_rd = 0; done_cnt = 0;
        first_valid = -1; last_beat = -1; done_cyc = -1; hold = 1'b0; rdy_mode = 0;
        for (int k = 0; k < NPIX; k++) mem[k] = (k << SHIFT) & 1023;

        #1 rst = 1'b1;
        #1 chk_all_zero("reset_async_outputs");
        repeat (3) @(posedge clk25);
        #1;
        chk_all_zero("reset_held_outputs");
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_no_beats", beats + issued, 0);

        // Ramp frame, consumer always ready: latency and back-to-back beats.
        rdy_mode = 0;
        begin_frame();
        wait_done(2000);
        chk("first_valid_lat", first_valid, 2);
        chk("stream_span", last_beat - first_valid, NPIX - 1);

        // Max-sum frame; start during the done pulse must be ignored.
        for (int k = 0; k < NPIX; k++) mem[k] = 992;
        begin_frame();
        n = 0;
        while (beats < NPIX && n < 3000) begin
            tick();
            n++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_seen_992", done_cnt, 1);
        chk("beats_992", beats, NPIX);
        snap_issued = issued;
        repeat (10) tick();
        chk("start_in_done_ignored", issued - snap_issued, 0);
        chk("idle_busy_low", int'(busy), 0);
        chk("idle_valid_low", int'(px_valid), 0);

        // Random data, random back-pressure.
        for (int k = 0; k < NPIX; k++) mem[k] = int'($urandom_range(0, 1023));
        rdy_mode = 1;
        begin_frame();
        wait_done(8000);

        // Consumer blocked for 100 cycles right after start.
        mem[0] = 960;
        rdy_mode = 2;
        begin_frame();
        repeat (100) tick();
        chk("stall_rd_pulses_le2", int'(issued <= 2), 1);
        chk("stall_no_beats", beats, 0);
        chk("stall_hold_valid", int'(px_valid), 1);
        chk("stall_hold_word0", int'(px_data), exp_px(0));
        chk("stall_hold_first", int'(px_first), 1);
        rdy_mode = 0;
        wait_done(2000);

        // Start re-pulsed mid-frame.
        for (int k = 0; k < NPIX; k++) mem[k] = (k << SHIFT) & 1023;
        begin_frame();
        n = 0;
        while (beats < 500 && n < 2000) begin
            tick();
            n++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_mid_frame", int'(busy), 1);
        wait_done(2000);
        chk("span_with_restart", last_beat - first_valid, NPIX - 1);

        // Reset mid-frame, then a clean restart from address 0.
        begin_frame();
        n = 0;
        while (beats < 300 && n < 2000) begin
            tick();
            n++;
        end
        #2 rst = 1'b1;
        #1 chk_all_zero("midframe_reset_outputs");
        tick();
        tick();
        rst = 1'b0;
        snap_beats = beats;
        snap_issued = issued;
        repeat (30) tick();
        chk("post_reset_no_beats", beats - snap_beats, 0);
        chk("post_reset_no_reads", issued - snap_issued, 0);
        chk("post_reset_idle", int'(busy), 0);
        begin_frame();
        wait_done(2000);
        chk("restart_first_valid_lat", first_valid, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
